trace_buffer: RTL and testbench

Synthesizable execution-trace capture unit for the 16-bit CPU. It records retired-instruction events (PC, instruction word, zero flag, timestamp) into a parametrised circular buffer. Capture runs in one of three modes: wrap, fill, or trigger-with-post-count. Afterwards it streams entries out oldest-first over a valid/ready port, replacing $display-style cycle dumps with on-chip capture readable by a bench or a debug host.

---
 rtl/trace_buffer.sv | 166 ++++++++++++++++
 tb/tb_trace_buffer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/trace_buffer.sv
// trace_buffer: captures retired-instruction events into a circular buffer.
// Capture runs in wrap, fill or trigger-with-post-count mode. Entries are then
// streamed out oldest-first over a valid/ready port.
module trace_buffer #(
  parameter int unsigned PC_W    = 12,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TS_W    = 16,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned CW      = AW + 1,
  localparam int unsigned ENTRY_W = TS_W + 1 + PC_W + INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               in_zero,
  input  logic [1:0]         mode,
  input  logic               arm,
  input  logic               stop,
  input  logic [PC_W-1:0]    trig_pc,
  input  logic [AW-1:0]      post_count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ENTRY_W-1:0] out_data,
  output logic [CW-1:0]      count,
  output logic [1:0]         state,
  output logic               triggered,
  output logic               overflow
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StPost    = 2'd2,
    StDone    = 2'd3
  } state_e;

  localparam logic [1:0] ModeFill  = 2'd1;
  localparam logic [1:0] ModeTrig  = 2'd2;
  localparam logic [1:0] ModeFill3 = 2'd3;

  state_e               state_q, state_d;
  logic [TS_W-1:0]      ts_q;
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        remaining_q;
  logic [CW-1:0]        count_q;
  logic [1:0]           mode_q;
  logic                 triggered_q;
  logic                 overflow_q;
  logic [ENTRY_W-1:0]   mem [DEPTH];

  logic                 capturing;
  logic                 wr_en;
  logic                 is_fill;
  logic                 is_trig;
  logic                 full;
  logic                 trig_hit;
  logic                 start;
  logic                 pop;
  logic [AW-1:0]        rd_ptr;

  assign capturing = (state_q == StCapture) || (state_q == StPost);
  assign wr_en     = capturing && in_valid;
  assign is_fill   = (mode_q == ModeFill) || (mode_q == ModeFill3);
  assign is_trig   = (mode_q == ModeTrig);
  assign full      = (count_q == CW'(DEPTH));
  // Only the first match in CAPTURE triggers; POST never re-arms the trigger.
  assign trig_hit  = wr_en && (state_q == StCapture) && is_trig && !triggered_q &&
                     (in_pc == trig_pc);
  assign start     = arm && ((state_q == StIdle) || (state_q == StDone));
  assign pop       = out_valid && out_ready;
  // Oldest entry sits count slots behind the write pointer (mod DEPTH).
  assign rd_ptr    = wr_ptr_q - count_q[AW-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stop forces DONE after any same-cycle write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (arm) state_d = StCapture;
      end
      StCapture: begin
        if (wr_en && is_fill && (count_q == CW'(DEPTH - 1))) begin
          state_d = StDone;
        end else if (trig_hit) begin
          state_d = (post_count == '0) ? StDone : StPost;
        end
        if (stop) state_d = StDone;
      end
      StPost: begin
        if (wr_en && (remaining_q == AW'(1))) state_d = StDone;
        if (stop) state_d = StDone;
      end
      StDone: begin
        if (arm) state_d = StCapture;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state and stored entries.
  always_comb begin
    state     = state_q;
    out_valid = (state_q == StDone) && (count_q != '0);
    out_data  = mem[rd_ptr];
    count     = count_q;
    triggered = triggered_q;
    overflow  = overflow_q;
  end

  // Timestamp, pointers, occupancy and capture flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q        <= '0;
      wr_ptr_q    <= '0;
      remaining_q <= '0;
      count_q     <= '0;
      mode_q      <= '0;
      triggered_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (start) begin
        wr_ptr_q    <= '0;
        count_q     <= '0;
        triggered_q <= 1'b0;
        overflow_q  <= 1'b0;
        mode_q      <= mode;
      end else if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        if (full) begin
          overflow_q <= 1'b1;
        end else begin
          count_q <= count_q + CW'(1);
        end
        if (trig_hit) begin
          triggered_q <= 1'b1;
          remaining_q <= post_count;
        end else if (state_q == StPost) begin
          remaining_q <= remaining_q - AW'(1);
        end
      end else if (pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Entry storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= {ts_q, in_zero, in_pc, in_instr};
    end
  end

endmodule

// File: tb/tb_trace_buffer.sv
// tb_trace_buffer: directed checks of capture modes, readout, backpressure,
// timestamps and reset behaviour with DEPTH=4.
module tb_trace_buffer;

  localparam int unsigned PC_W    = 12;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TS_W    = 16;
  localparam int unsigned AW      = 2;
  localparam int unsigned CW      = 3;
  localparam int unsigned ENTRY_W = TS_W + 1 + PC_W + INSTR_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               in_zero;
  logic [1:0]         mode;
  logic               arm;
  logic               stop;
  logic [PC_W-1:0]    trig_pc;
  logic [AW-1:0]      post_count;
  logic               out_valid;
  logic               out_ready;
  logic [ENTRY_W-1:0] out_data;
  logic [CW-1:0]      count;
  logic [1:0]         state;
  logic               triggered;
  logic               overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  trace_buffer #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .TS_W    (TS_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_pc      (in_pc),
    .in_instr   (in_instr),
    .in_zero    (in_zero),
    .mode       (mode),
    .arm        (arm),
    .stop       (stop),
    .trig_pc    (trig_pc),
    .post_count (post_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .count      (count),
    .state      (state),
    .triggered  (triggered),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [63:0] pc_of(input logic [ENTRY_W-1:0] e);
    return 64'(e[INSTR_W +: PC_W]);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic arm_mode(input logic [1:0] m);
    mode = m;
    arm  = 1'b1;
    tick();
    arm  = 1'b0;
  endtask

  task automatic push(input int pc);
    in_valid = 1'b1;
    in_pc    = PC_W'(pc);
    in_instr = INSTR_W'(16'hA000 + pc);
    in_zero  = pc[0];
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input int pc);
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_pc"}, pc_of(out_data), 64'(pc));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; in_zero = 1'b0;
    mode = 2'd0; arm = 1'b0; stop = 1'b0; trig_pc = '0; post_count = '0;
    out_ready = 1'b0;

    // Reset state.
    do_reset();
    check_eq("rst_state", 64'(state), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_trig", 64'(triggered), 64'd0);
    check_eq("rst_ovf", 64'(overflow), 64'd0);

    // Timestamps: arm at cycle 2, entries at cycles 5 and 9.
    while (cyc < 2) tick();
    arm_mode(2'd1);
    check_eq("ts_capture", 64'(state), 64'd1);
    while (cyc < 5) tick();
    in_valid = 1'b1; in_pc = 12'h011; in_instr = 16'h0123; in_zero = 1'b1;
    tick();
    in_valid = 1'b0;
    while (cyc < 9) tick();
    in_valid = 1'b1; in_pc = 12'h022; in_instr = 16'h7004; in_zero = 1'b0;
    tick();
    in_valid = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("ts_done", 64'(state), 64'd3);
    check_eq("ts_count", 64'(count), 64'd2);
    check_eq("ts_first", 64'(out_data[ENTRY_W-1 -: TS_W]), 64'd5);
    check_eq("ts_first_instr", 64'(out_data[INSTR_W-1:0]), 64'h0123);
    check_eq("ts_first_zero", 64'(out_data[PC_W+INSTR_W]), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("ts_second", 64'(out_data[ENTRY_W-1 -: TS_W]), 64'd9);
    check_eq("ts_second_instr", 64'(out_data[INSTR_W-1:0]), 64'h7004);
    check_eq("ts_second_zero", 64'(out_data[PC_W+INSTR_W]), 64'd0);

    // FILL: completes on the fourth write, fifth is dropped.
    do_reset();
    arm_mode(2'd1);
    for (int i = 0; i < 5; i++) begin
      push(i);
      if (i == 3) check_eq("fill_done", 64'(state), 64'd3);
    end
    check_eq("fill_count", 64'(count), 64'd4);
    check_eq("fill_ovf", 64'(overflow), 64'd0);
    check_eq("fill_trig", 64'(triggered), 64'd0);
    for (int i = 0; i < 4; i++) pop_check("fill_pop", i);
    check_eq("fill_empty", 64'(out_valid), 64'd0);
    check_eq("fill_stay_done", 64'(state), 64'd3);

    // WRAP, restarted from DONE: keeps the newest four.
    arm_mode(2'd0);
    check_eq("wrap_rearm", 64'(state), 64'd1);
    for (int i = 0; i < 6; i++) push(i);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("wrap_done", 64'(state), 64'd3);
    check_eq("wrap_count", 64'(count), 64'd4);
    check_eq("wrap_ovf", 64'(overflow), 64'd1);
    for (int i = 2; i < 6; i++) pop_check("wrap_pop", i);
    check_eq("wrap_empty", 64'(out_valid), 64'd0);

    // TRIG on pc 5 with two post entries.
    trig_pc = 12'd5;
    post_count = 2'd2;
    arm_mode(2'd2);
    for (int i = 0; i < 10; i++) begin
      push(i);
      if (i == 5) check_eq("trig_post", 64'(state), 64'd2);
      if (i == 7) check_eq("trig_done", 64'(state), 64'd3);
    end
    check_eq("trig_flag", 64'(triggered), 64'd1);
    check_eq("trig_ovf", 64'(overflow), 64'd1);
    check_eq("trig_count", 64'(count), 64'd4);
    for (int i = 4; i < 8; i++) pop_check("trig_pop", i);

    // Backpressure in DONE.
    arm_mode(2'd0);
    for (int i = 10; i < 14; i++) push(i);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("bp_hold_pc", pc_of(out_data), 64'd10);
      check_eq("bp_hold_count", 64'(count), 64'd4);
    end
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    check_eq("bp_count", 64'(count), 64'd2);
    check_eq("bp_pc", pc_of(out_data), 64'd12);

    // Reset mid-capture, then stop with a same-cycle entry.
    arm_mode(2'd0);
    push(1);
    push(2);
    check_eq("mid_count", 64'(count), 64'd2);
    do_reset();
    check_eq("mid_rst_state", 64'(state), 64'd0);
    check_eq("mid_rst_count", 64'(count), 64'd0);
    check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
    arm_mode(2'd0);
    in_valid = 1'b1; in_pc = 12'h077; in_instr = 16'h1234; in_zero = 1'b1;
    stop = 1'b1;
    tick();
    in_valid = 1'b0;
    stop = 1'b0;
    check_eq("stopw_state", 64'(state), 64'd3);
    check_eq("stopw_count", 64'(count), 64'd1);
    check_eq("stopw_pc", pc_of(out_data), 64'h077);
    // Entry captured in cycle 1 after reset, so ts restarted from 0.
    check_eq("stopw_ts", 64'(out_data[ENTRY_W-1 -: TS_W]), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
